// File: rtl/btn_input_ctrl_if.sv
// Button front-end bus: raw inputs and controls toward the channel logic,
// debounced level, pulses and press counters back to the consumer.
interface btn_input_ctrl_if #(
  parameter int NUM_BTN   = 3,
  parameter int CNT_WIDTH = 16
);
  logic [NUM_BTN-1:0]           btn_raw;
  logic [NUM_BTN-1:0]           repeat_en;
  logic [NUM_BTN-1:0]           cnt_clr;
  logic [NUM_BTN-1:0]           btn_level;
  logic [NUM_BTN-1:0]           btn_press;
  logic [NUM_BTN-1:0]           btn_release;
  logic [NUM_BTN-1:0]           btn_long;
  logic [NUM_BTN*CNT_WIDTH-1:0] press_cnt;

  modport master (
    output btn_raw, repeat_en, cnt_clr,
    input  btn_level, btn_press, btn_release, btn_long, press_cnt
  );

  modport slave (
    input  btn_raw, repeat_en, cnt_clr,
    output btn_level, btn_press, btn_release, btn_long, press_cnt
  );
endinterface

// File: rtl/btn_input_ctrl.sv
// Multi-channel button front end: synchroniser, debounce, press/release pulses,
// long-press detection, optional auto-repeat and a wrap/saturate press counter.
module btn_input_ctrl #(
  parameter int NUM_BTN       = 3,
  parameter int DB_CYCLES     = 100000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_WIDTH     = 16,
  parameter int SAT_CNT       = 0
) (
  input logic             sys_clk,
  input logic             sys_rst,
  btn_input_ctrl_if.slave bus
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int RW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DBW-1:0]       DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0]       DB_ONE    = DBW'(1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]        HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0]        REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0]        REP_ONE   = RW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam bit                   SAT       = (SAT_CNT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  logic [NUM_BTN-1:0]           level_v;
  logic [NUM_BTN-1:0]           press_v;
  logic [NUM_BTN-1:0]           release_v;
  logic [NUM_BTN-1:0]           long_v;
  logic [NUM_BTN*CNT_WIDTH-1:0] cnt_v;

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_long    = long_v;
  assign bus.press_cnt   = cnt_v;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic                 s1_r, s2_r;
    logic                 level_r, level_s;
    logic [DBW-1:0]       db_cnt_r, db_cnt_s;
    state_t               state_r, state_s;
    logic [HW-1:0]        hold_cnt_r, hold_cnt_s;
    logic [RW-1:0]        rep_cnt_r, rep_cnt_s;
    logic                 press_r, press_s;
    logic                 release_r, release_s;
    logic                 long_r, long_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
    logic                 rise_s, fall_s;

    // Any sample agreeing with the current level restarts the debounce count.
    always_comb begin
      level_s  = level_r;
      db_cnt_s = '0;
      if (s2_r == level_r) begin
        db_cnt_s = '0;
      end else if (db_cnt_r == DB_LAST) begin
        level_s  = s2_r;
        db_cnt_s = '0;
      end else begin
        db_cnt_s = db_cnt_r + DB_ONE;
      end
    end

    assign rise_s = level_s & ~level_r;
    assign fall_s = level_r & ~level_s;

    // Hold/repeat FSM; a falling level always wins over entering LONG.
    always_comb begin
      state_s    = state_r;
      hold_cnt_s = hold_cnt_r;
      rep_cnt_s  = rep_cnt_r;
      press_s    = 1'b0;
      release_s  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_s    = ST_HELD;
            press_s    = 1'b1;
            hold_cnt_s = '0;
            rep_cnt_s  = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (fall_s) begin
            state_s    = ST_IDLE;
            release_s  = 1'b1;
            hold_cnt_s = '0;
            rep_cnt_s  = '0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_s    = ST_LONG;
            press_s    = bus.repeat_en[i];
            hold_cnt_s = '0;
            rep_cnt_s  = '0;
          end else begin
            hold_cnt_s = hold_cnt_r + HOLD_ONE;
          end
        end
        ST_LONG: begin
          if (fall_s) begin
            state_s    = ST_IDLE;
            release_s  = 1'b1;
            hold_cnt_s = '0;
            rep_cnt_s  = '0;
          end else if (rep_cnt_r == REP_LAST) begin
            rep_cnt_s = '0;
            press_s   = bus.repeat_en[i];
          end else begin
            rep_cnt_s = rep_cnt_r + REP_ONE;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          hold_cnt_s = '0;
          rep_cnt_s  = '0;
        end
      endcase
      long_s = (state_s == ST_LONG);
    end

    // Counter sees the registered pulse, so it lags the pulse by one edge.
    always_comb begin
      cnt_s = cnt_r;
      if (bus.cnt_clr[i]) begin
        cnt_s = '0;
      end else if (press_r) begin
        if (SAT && (cnt_r == CNT_MAX)) begin
          cnt_s = cnt_r;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end else begin
        cnt_s = cnt_r;
      end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        s1_r       <= 1'b0;
        s2_r       <= 1'b0;
        level_r    <= 1'b0;
        db_cnt_r   <= '0;
        state_r    <= ST_IDLE;
        hold_cnt_r <= '0;
        rep_cnt_r  <= '0;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        long_r     <= 1'b0;
        cnt_r      <= '0;
      end else begin
        s1_r       <= bus.btn_raw[i];
        s2_r       <= s1_r;
        level_r    <= level_s;
        db_cnt_r   <= db_cnt_s;
        state_r    <= state_s;
        hold_cnt_r <= hold_cnt_s;
        rep_cnt_r  <= rep_cnt_s;
        press_r    <= press_s;
        release_r  <= release_s;
        long_r     <= long_s;
        cnt_r      <= cnt_s;
      end
    end

    assign level_v[i]                        = level_r;
    assign press_v[i]                        = press_r;
    assign release_v[i]                      = release_r;
    assign long_v[i]                         = long_r;
    assign cnt_v[i*CNT_WIDTH +: CNT_WIDTH]   = cnt_r;
  end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl: wrap-mode DUT for the main scenarios and a
// saturating DUT driven alongside it for the counter limit.
module tb_btn_input_ctrl;

  logic sys_clk;
  logic sys_rst;
  int   n_chk;
  int   n_pass;
  int   np;
  int   nr;
  logic [63:0] pv, rv, ep, er;

  btn_input_ctrl_if #(.NUM_BTN(3), .CNT_WIDTH(4)) bus0 ();
  btn_input_ctrl_if #(.NUM_BTN(3), .CNT_WIDTH(4)) bus1 ();

  btn_input_ctrl #(
    .NUM_BTN(3), .DB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
    .CNT_WIDTH(4), .SAT_CNT(0)
  ) u_dut_wrap (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0.slave)
  );

  btn_input_ctrl #(
    .NUM_BTN(3), .DB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
    .CNT_WIDTH(4), .SAT_CNT(1)
  ) u_dut_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    sys_rst = 1'b1;
    bus0.btn_raw = 3'b000; bus0.repeat_en = 3'b000; bus0.cnt_clr = 3'b000;
    bus1.btn_raw = 3'b000; bus1.repeat_en = 3'b000; bus1.cnt_clr = 3'b000;
    ticks(2);
    check("rst_outputs", {bus0.btn_level, bus0.btn_press, bus0.btn_release,
                          bus0.btn_long, bus0.press_cnt}, 64'd0);
    sys_rst = 1'b0;
    ticks(2);

    // Clean press on channel 0
    bus0.btn_raw[0] = 1'b1;
    tick();
    ticks(4);
    check("t1_level_e4", bus0.btn_level[0], 64'd0);
    tick();
    check("t1_level_e5", bus0.btn_level[0], 64'd1);
    check("t1_press_e5", bus0.btn_press[0], 64'd1);
    check("t1_cnt_e5", bus0.press_cnt[3:0], 64'd0);
    tick();
    check("t1_press_e6", bus0.btn_press[0], 64'd0);
    check("t1_cnt_e6", bus0.press_cnt[3:0], 64'd1);
    ticks(8);
    bus0.btn_raw[0] = 1'b0;
    tick();
    ticks(4);
    check("t1_rel_f4", {bus0.btn_release[0], bus0.btn_level[0]}, 64'd1);
    tick();
    check("t1_rel_f5", {bus0.btn_release[0], bus0.btn_level[0], bus0.btn_long[0]}, 64'd4);
    tick();
    check("t1_rel_f6", bus0.btn_release[0], 64'd0);

    // Glitch of 3 cycles on channel 1
    np = 0;
    bus0.btn_raw[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      np = np + int'(bus0.btn_press[1]);
    end
    bus0.btn_raw[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      np = np + int'(bus0.btn_press[1]);
    end
    check("t2_glitch_level", bus0.btn_level[1], 64'd0);
    check("t2_glitch_press", np, 64'd0);
    check("t2_glitch_cnt", bus0.press_cnt[7:4], 64'd0);

    // Bounce 1,1,1,0,1,1,1,1: level rises two edges after the 4th good sample
    pv = 64'h00000000000000F7;
    for (int k = 0; k < 8; k++) begin
      bus0.btn_raw[1] = pv[k];
      tick();
    end
    tick();
    check("t2_bounce_e8", bus0.btn_level[1], 64'd0);
    tick();
    check("t2_bounce_e9", {bus0.btn_level[1], bus0.btn_press[1]}, 64'd3);
    bus0.btn_raw[1] = 1'b0;
    ticks(7);
    check("t2_bounce_cnt", bus0.press_cnt[7:4], 64'd1);
    ticks(2);

    // Long press on channel 2 without repeat
    bus0.btn_raw[2] = 1'b1;
    ticks(6);
    check("t3_press_r0", bus0.btn_press[2], 64'd1);
    np = 0;
    nr = 0;
    for (int r = 1; r <= 40; r++) begin
      if (r == 35) bus0.btn_raw[2] = 1'b0;
      tick();
      np = np + int'(bus0.btn_press[2]);
      nr = nr + int'(bus0.btn_release[2]);
      if (r == 19) check("t3_long_r19", bus0.btn_long[2], 64'd0);
      if (r == 20) check("t3_long_r20", bus0.btn_long[2], 64'd1);
      if (r == 39) check("t3_long_r39", bus0.btn_long[2], 64'd1);
      if (r == 40) check("t3_long_r40", {bus0.btn_long[2], bus0.btn_release[2]}, 64'd1);
    end
    check("t3_extra_press", np, 64'd0);
    check("t3_release_cnt", nr, 64'd1);
    tick();
    check("t3_cnt", bus0.press_cnt[11:8], 64'd1);
    ticks(3);

    // Auto-repeat on channel 0, then with repeat_en dropped at relative edge 30
    for (int pass = 0; pass < 2; pass++) begin
      bus0.cnt_clr[0] = 1'b1;
      tick();
      bus0.cnt_clr[0] = 1'b0;
      check("t4_clr", bus0.press_cnt[3:0], 64'd0);
      bus0.repeat_en[0] = 1'b1;
      bus0.btn_raw[0] = 1'b1;
      ticks(5);
      pv = 64'd0;
      rv = 64'd0;
      for (int r = 0; r <= 40; r++) begin
        if (r == 35) bus0.btn_raw[0] = 1'b0;
        if (r == 30 && pass == 1) bus0.repeat_en[0] = 1'b0;
        tick();
        pv[r] = bus0.btn_press[0];
        rv[r] = bus0.btn_release[0];
      end
      ep = 64'd0;
      ep[0] = 1'b1; ep[20] = 1'b1; ep[28] = 1'b1;
      if (pass == 0) ep[36] = 1'b1;
      er = 64'd0;
      er[40] = 1'b1;
      check(pass == 0 ? "t4_rep_pulses" : "t4_rep_drop_pulses", pv, ep);
      check("t4_rep_release", rv, er);
      tick();
      check(pass == 0 ? "t4_rep_cnt" : "t4_rep_drop_cnt", bus0.press_cnt[3:0],
            (pass == 0) ? 64'd4 : 64'd3);
      bus0.repeat_en[0] = 1'b0;
      ticks(3);
    end

    // 17 presses on channel 1 of both DUTs: wrap vs saturate
    bus0.cnt_clr[1] = 1'b1;
    tick();
    bus0.cnt_clr[1] = 1'b0;
    for (int p = 0; p < 17; p++) begin
      bus0.btn_raw[1] = 1'b1; bus1.btn_raw[1] = 1'b1;
      ticks(7);
      bus0.btn_raw[1] = 1'b0; bus1.btn_raw[1] = 1'b0;
      ticks(7);
    end
    check("t5_wrap_cnt", bus0.press_cnt[7:4], 64'd1);
    check("t5_sat_cnt", bus1.press_cnt[7:4], 64'd15);

    // Clear in the pulse cycle wins over the increment
    bus0.btn_raw[1] = 1'b1;
    ticks(6);
    check("t5_clr_pulse", bus0.btn_press[1], 64'd1);
    bus0.cnt_clr[1] = 1'b1;
    tick();
    bus0.cnt_clr[1] = 1'b0;
    check("t5_clr_cnt", bus0.press_cnt[7:4], 64'd0);
    tick();
    check("t5_clr_cnt_hold", bus0.press_cnt[7:4], 64'd0);
    bus0.btn_raw[1] = 1'b0;
    ticks(8);

    // Simultaneous presses on channels 0 and 2
    bus0.cnt_clr = 3'b101;
    tick();
    bus0.cnt_clr = 3'b000;
    bus0.btn_raw = 3'b101;
    ticks(6);
    check("t5_par_press", bus0.btn_press, 64'd5);
    tick();
    check("t5_par_cnt", {bus0.press_cnt[11:8], bus0.press_cnt[3:0]}, 64'h11);
    bus0.btn_raw = 3'b000;
    ticks(8);

    // Reset while in LONG on channel 0, raw still high afterwards
    bus0.btn_raw[0] = 1'b1;
    ticks(6);
    ticks(20);
    check("t6_long_before", bus0.btn_long[0], 64'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("t6_rst_outputs", {bus0.btn_level, bus0.btn_press, bus0.btn_release,
                             bus0.btn_long, bus0.press_cnt}, 64'd0);
    np = 0;
    nr = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      np = np + int'(bus0.btn_press[0]);
      nr = nr + int'(bus0.btn_release[0]);
    end
    check("t6_no_early_press", np, 64'd0);
    check("t6_no_release", nr, 64'd0);
    tick();
    check("t6_repress", {bus0.btn_level[0], bus0.btn_press[0]}, 64'd3);
    tick();
    check("t6_cnt", bus0.press_cnt[3:0], 64'd1);
    bus0.btn_raw[0] = 1'b0;
    ticks(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/btn_input_ctrl.md
Name: btn_input_ctrl

Overview:
- Parametrised multi-channel button front end that replaces the per-button debounce, edge-detect and press-counter logic in the top level.
- Per channel it provides:
  - 2-flop synchroniser
  - counter-based debounce
  - press and release pulses
  - long-press detection
  - optional auto-repeat
  - press counter, selectable wrap or saturate
- Sits between the board buttons and the character/debug logic; all channels share one clock.

Parameters:
- NUM_BTN, 3, number of independent button channels.
- DB_CYCLES, 100000, consecutive differing sync samples required to flip the debounced level (≥2).
- LONG_CYCLES, 50000000, cycles the level must stay high after the press edge before btn_long asserts (≥1).
- REPEAT_CYCLES, 10000000, auto-repeat period once long-press is reached (≥1).
- CNT_WIDTH, 16, press counter width per channel.
- SAT_CNT, 0, 0 = counter wraps, 1 = counter saturates at 2^CNT_WIDTH-1.

Ports:
- sys_clk, input, 1, system clock.
- sys_rst, input, 1, reset; synchronous, active-high.
- btn_raw, input, NUM_BTN, asynchronous raw button inputs, bit i = channel i.
- repeat_en, input, NUM_BTN, per-channel auto-repeat enable.
- cnt_clr, input, NUM_BTN, per-channel synchronous press-counter clear.
- btn_level, output, NUM_BTN, debounced level.
- btn_press, output, NUM_BTN, 1-cycle pulse on press edge and on each auto-repeat.
- btn_release, output, NUM_BTN, 1-cycle pulse on debounced falling edge.
- btn_long, output, NUM_BTN, high while held at or beyond LONG_CYCLES.
- press_cnt, output, NUM_BTN*CNT_WIDTH, counters; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- **Reset:** when sys_rst is high at a sys_clk edge, all of the following go to 0 at that edge:
  - synchronisers, debounce counters, hold/repeat timers, FSMs
  - every output: btn_level, btn_press, btn_release, btn_long, press_cnt
- **Reset mid-operation:** aborts everything with no pulses. A button still high after reset is treated as a new press once debounced.
- **Synchroniser:** s1 <= btn_raw, s2 <= s1.
- **Debounce counter (db_cnt per channel):**
  - If s2 == level, db_cnt <= 0.
  - If s2 != level and db_cnt == DB_CYCLES-1, level <= s2 and db_cnt <= 0.
  - Otherwise db_cnt++.
  - Any agreeing sample restarts the count, so glitches shorter than DB_CYCLES cycles are ignored.
- **Latency:** raw change first captured by s1 at edge k → btn_level changes at edge k+1+DB_CYCLES.
- **FSM per channel:**
  - IDLE → HELD when level rises. btn_press=1 for one cycle, registered on the same edge as the level change.
  - HELD: hold_cnt increments each cycle. When hold_cnt reaches LONG_CYCLES-1, go to LONG and set btn_long=1. Net effect: btn_long rises exactly LONG_CYCLES edges after level rise.
  - LONG entry, repeat_en[i]=1: emit a repeat btn_press on the LONG entry edge, then every REPEAT_CYCLES edges while in LONG.
  - LONG, repeat_en[i]=0: no repeat pulses. repeat_en is sampled every cycle, so a mid-hold change takes effect immediately; the repeat timer is not reset.
  - HELD or LONG → IDLE when level falls. Same edge: btn_release=1 for 1 cycle, btn_long=0, timers cleared.
  - Level falling on the same edge LONG would be entered: release wins, no btn_long, no repeat pulse.
- **Counter:**
  - press_cnt[i] increments by 1 on each btn_press[i] pulse, whether from a press or a repeat.
  - SAT_CNT=0: max+1 wraps to 0. SAT_CNT=1: holds at max.
  - cnt_clr has priority: clear and pulse on the same cycle → counter 0, btn_press still emitted.
  - Counter is updated on the edge after the pulse: a pulse visible in cycle n is counted at the edge ending cycle n.
- **Channel independence:** channels are fully independent; simultaneous events on different channels are handled in parallel.
- **Register widths:**
  - db_cnt: $clog2(DB_CYCLES)
  - hold_cnt: $clog2(LONG_CYCLES)
  - repeat timer: $clog2(REPEAT_CYCLES)
  - no timer wraps inside a state.

Test Plan (DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, CNT_WIDTH=4, NUM_BTN=3):
1. **Clean press:** btn_raw[0] rises, captured by s1 at edge 0, held 15 cycles → btn_level[0]=1 and btn_press[0] pulse at edge 5, press_cnt[0]=1 at edge 6. btn_release[0] pulses 5 edges after the falling capture; btn_long never asserts.
2. **Glitch rejection:** btn_raw[1] high for 3 cycles, then low → btn_level, btn_press and press_cnt[1] stay 0. Also check a bounce pattern 1,1,1,0,1,1,1,1 → single press, level rises at the 4th consecutive 1.
3. **Long press, repeat_en=0:** level high 40 cycles → btn_long rises 20 edges after level rise and falls on the release edge. Exactly one press and one release; press_cnt=1.
4. **Auto-repeat, repeat_en=1:** level high 40 cycles → btn_press at relative edges 0, 20, 28, 36; press_cnt=4. Dropping repeat_en at relative 30 → pulses only at 0, 20, 28; press_cnt=3.
5. **Counter limits:**
   - SAT_CNT=0, 17 presses → press_cnt=1.
   - SAT_CNT=1, 17 presses → press_cnt=15.
   - cnt_clr asserted in the press-pulse cycle → press_cnt=0, pulse still seen.
   - Channels 0 and 2 pressed simultaneously → both counters = 1.
6. **Reset mid-hold:** sys_rst in LONG for one cycle → next edge all outputs 0, no release pulse. With raw still high, btn_press re-occurs 2+DB_CYCLES edges after reset release; press_cnt=1.
